// File: rtl/roi_frame_sequencer_if.sv
// Video stream handshake bundle observed by the ROI frame sequencer.
// The sequencer only listens, so its modport takes every signal as an input.
interface roi_frame_sequencer_if;
    logic s_tvalid;
    logic s_tready;
    logic s_tuser;
    logic s_tlast;

    modport master (output s_tvalid, output s_tready, output s_tuser, output s_tlast);
    modport slave  (input  s_tvalid, input  s_tready, input  s_tuser, input  s_tlast);
endinterface

// File: rtl/roi_frame_sequencer.sv
// Frame sequencer and row-window gate for the AXI4-Stream video path.
// It tracks row and column from the SOF/EOL markers, flags framing errors and counts frames.
module roi_frame_sequencer #(
    parameter int unsigned IMG_WIDTH  = 416,
    parameter int unsigned IMG_HEIGHT = 416,
    parameter int unsigned FCNT_W     = 16,
    localparam int unsigned RW = $clog2(IMG_HEIGHT),
    localparam int unsigned CW = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    roi_frame_sequencer_if.slave  s,
    input  logic                  cfg_en,
    input  logic                  cfg_wr,
    input  logic [RW-1:0]         cfg_row_start,
    input  logic [RW-1:0]         cfg_row_end,
    output logic                  pix_valid,
    output logic                  roi_sof,
    output logic [RW-1:0]         row_idx,
    output logic [CW-1:0]         col_idx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_early_eol,
    output logic                  err_late_eol,
    output logic                  err_sof_mid,
    output logic [FCNT_W-1:0]     frame_cnt
);

    typedef enum logic {StIdle, StActive} state_e;

    localparam logic [RW-1:0] LastRow = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] LastCol = CW'(IMG_WIDTH - 1);

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     shd_start_q, shd_start_d, shd_end_q, shd_end_d;
    logic [RW-1:0]     win_start_q, win_start_d, win_end_q, win_end_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d, early_q, early_d, late_q, late_d, mid_q, mid_d;

    logic              hs;
    logic [RW-1:0]     cur_row, cur_start, cur_end;
    logic [CW-1:0]     cur_col;
    logic              frame_ok, in_win;

    assign hs = s.s_tvalid & s.s_tready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_start_d = win_start_q;
        win_end_d   = win_end_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        early_d     = 1'b0;
        late_d      = 1'b0;
        mid_d       = 1'b0;
        // The shadow updates at the same edge an SOF latches, so that SOF sees the old value.
        shd_start_d = cfg_wr ? cfg_row_start : shd_start_q;
        shd_end_d   = cfg_wr ? cfg_row_end   : shd_end_q;

        unique case (state_q)
            StIdle: begin
                if (hs && s.s_tuser && cfg_en) begin
                    state_d     = StActive;
                    win_start_d = shd_start_q;
                    win_end_d   = shd_end_q;
                    row_d       = '0;
                    col_d       = CW'(1);
                end
            end
            StActive: begin
                if (hs) begin
                    if (s.s_tuser) begin
                        // Resynchronise: treat as a fresh SOF; any EOL on this beat is ignored.
                        mid_d       = 1'b1;
                        win_start_d = shd_start_q;
                        win_end_d   = shd_end_q;
                        row_d       = '0;
                        col_d       = CW'(1);
                    end else if (s.s_tlast) begin
                        early_d = (col_q < LastCol);
                        if (row_q == LastRow) begin
                            done_d  = 1'b1;
                            cnt_d   = cnt_q + FCNT_W'(1);
                            state_d = StIdle;
                            row_d   = '0;
                            col_d   = '0;
                        end else begin
                            row_d = row_q + RW'(1);
                            col_d = '0;
                        end
                    end else if (col_q == LastCol) begin
                        late_d  = 1'b1;
                        state_d = StIdle;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // An IDLE SOF beat is judged at row 0 against the shadow window it is about to latch.
    always_comb begin
        if (state_q == StActive) begin
            cur_row   = row_q;
            cur_col   = col_q;
            cur_start = win_start_q;
            cur_end   = win_end_q;
            frame_ok  = 1'b1;
        end else begin
            cur_row   = '0;
            cur_col   = '0;
            cur_start = shd_start_q;
            cur_end   = shd_end_q;
            frame_ok  = s.s_tuser & cfg_en;
        end
        in_win    = (cur_row >= cur_start) && (cur_row <= cur_end);
        pix_valid = s.s_tvalid & in_win & frame_ok;
        roi_sof   = pix_valid & (cur_row == cur_start) & (cur_col == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            shd_start_q <= '0;
            shd_end_q   <= LastRow;
            win_start_q <= '0;
            win_end_q   <= LastRow;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            early_q     <= 1'b0;
            late_q      <= 1'b0;
            mid_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            shd_start_q <= shd_start_d;
            shd_end_q   <= shd_end_d;
            win_start_q <= win_start_d;
            win_end_q   <= win_end_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            early_q     <= early_d;
            late_q      <= late_d;
            mid_q       <= mid_d;
        end
    end

    assign row_idx       = row_q;
    assign col_idx       = col_q;
    assign busy          = (state_q == StActive);
    assign frame_done    = done_q;
    assign err_early_eol = early_q;
    assign err_late_eol  = late_q;
    assign err_sof_mid   = mid_q;
    assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_roi_frame_sequencer.sv
// Scoreboard bench for roi_frame_sequencer: per-beat expectations are queued when driven
// and compared when the beat is offered/handshaked; pulses are checked the following cycle.
module tb_roi_frame_sequencer;
    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    roi_frame_sequencer_if sif ();

    logic        cfg_en, cfg_wr;
    logic [2:0]  cfg_row_start, cfg_row_end;
    logic        pix_valid, roi_sof, busy, frame_done;
    logic        err_early_eol, err_late_eol, err_sof_mid;
    logic [2:0]  row_idx, col_idx;
    logic [15:0] frame_cnt;

    roi_frame_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FCNT_W     (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s             (sif),
        .cfg_en        (cfg_en),
        .cfg_wr        (cfg_wr),
        .cfg_row_start (cfg_row_start),
        .cfg_row_end   (cfg_row_end),
        .pix_valid     (pix_valid),
        .roi_sof       (roi_sof),
        .row_idx       (row_idx),
        .col_idx       (col_idx),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_early_eol (err_early_eol),
        .err_late_eol  (err_late_eol),
        .err_sof_mid   (err_sof_mid),
        .frame_cnt     (frame_cnt)
    );

    typedef struct {
        int row;
        int col;
        bit busy;
        bit pv;
        bit sof;
        bit done;
        bit early;
        bit late;
        bit mid;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_cnt, sof_cnt, done_cnt, early_cnt, late_cnt, mid_cnt;

    // Reference model state
    bit m_act;
    int m_row, m_col, m_ws, m_we, sh_s, sh_e, exp_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic clear_cnts();
        pv_cnt = 0; sof_cnt = 0; done_cnt = 0; early_cnt = 0; late_cnt = 0; mid_cnt = 0;
    endtask

    task automatic model_reset();
        m_act = 0; m_row = 0; m_col = 0;
        m_ws = 0; m_we = H - 1; sh_s = 0; sh_e = H - 1;
        exp_cnt = 0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend = '{default: 0};
        end else begin
            check_eq("frame_done", 32'(frame_done), 32'(pend.done));
            check_eq("err_early", 32'(err_early_eol), 32'(pend.early));
            check_eq("err_late", 32'(err_late_eol), 32'(pend.late));
            check_eq("err_sof_mid", 32'(err_sof_mid), 32'(pend.mid));
            if (pend.done) exp_cnt = (exp_cnt + 1) & 32'hffff;
            check_eq("frame_cnt", 32'(frame_cnt), exp_cnt);
            done_cnt  += int'(frame_done);
            early_cnt += int'(err_early_eol);
            late_cnt  += int'(err_late_eol);
            mid_cnt   += int'(err_sof_mid);
            pend = '{default: 0};
            if (sif.s_tvalid) begin
                check_eq("sb_depth", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check_eq("row_idx", 32'(row_idx), e.row);
                    check_eq("col_idx", 32'(col_idx), e.col);
                    check_eq("busy", 32'(busy), 32'(e.busy));
                    check_eq("pix_valid", 32'(pix_valid), 32'(e.pv));
                    check_eq("roi_sof", 32'(roi_sof), 32'(e.sof));
                    if (sif.s_tready) begin
                        void'(exp_q.pop_front());
                        pend = e;
                        pv_cnt  += int'(pix_valid);
                        sof_cnt += int'(roi_sof);
                    end
                end
            end else begin
                check_eq("pv_no_valid", 32'(pix_valid), 0);
            end
        end
    end

    task automatic send(input bit u, input bit l, input bit bp);
        exp_t e;
        bit   rdy, acc, inw;
        int   stalls = 0;
        int   cr, cc, ws, we;
        if (m_act) begin
            cr = m_row; cc = m_col; ws = m_ws; we = m_we; acc = 1;
        end else begin
            cr = 0; cc = 0; ws = sh_s; we = sh_e; acc = u && cfg_en;
        end
        inw     = (cr >= ws) && (cr <= we);
        e       = '{default: 0};
        e.row   = m_row;
        e.col   = m_col;
        e.busy  = m_act;
        e.pv    = acc && inw;
        e.sof   = e.pv && (cr == ws) && (cc == 0);
        if (m_act) begin
            if (u) e.mid = 1;
            else if (l) begin
                e.early = (m_col < W - 1);
                e.done  = (m_row == H - 1);
            end else e.late = (m_col == W - 1);
        end
        exp_q.push_back(e);
        sif.s_tvalid = 1'b1;
        sif.s_tuser  = u;
        sif.s_tlast  = l;
        do begin
            rdy = (!bp || stalls >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            sif.s_tready = rdy;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            if (rdy) begin
                if (!m_act) begin
                    if (u && cfg_en) begin
                        m_act = 1; m_ws = sh_s; m_we = sh_e; m_row = 0; m_col = 1;
                    end
                end else if (u) begin
                    m_ws = sh_s; m_we = sh_e; m_row = 0; m_col = 1;
                end else if (l) begin
                    if (m_row == H - 1) begin
                        m_act = 0; m_row = 0; m_col = 0;
                    end else begin
                        m_row++; m_col = 0;
                    end
                end else if (m_col == W - 1) begin
                    m_act = 0; m_row = 0; m_col = 0;
                end else begin
                    m_col++;
                end
            end
            if (cfg_wr) begin
                sh_s = int'(cfg_row_start); sh_e = int'(cfg_row_end); cfg_wr = 1'b0;
            end
        end while (!rdy);
    endtask

    task automatic idle(input int n);
        sif.s_tvalid = 1'b0; sif.s_tuser = 1'b0; sif.s_tlast = 1'b0; sif.s_tready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int st, input int en);
        cfg_row_start = 3'(st); cfg_row_end = 3'(en); cfg_wr = 1'b1;
        idle(1);
        sh_s = st; sh_e = en; cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        sif.s_tvalid = 1'b0; sif.s_tuser = 1'b0; sif.s_tlast = 1'b0;
        cfg_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_row", 32'(row_idx), 0);
        check_eq("rst_col", 32'(col_idx), 0);
        check_eq("rst_cnt", 32'(frame_cnt), 0);
        check_eq("rst_pulses", {28'd0, frame_done, err_early_eol, err_late_eol, err_sof_mid}, 0);
        check_eq("rst_pv", {30'd0, pix_valid, roi_sof}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drives one frame with optional anomalies; a negative row disables that anomaly.
    task automatic run_frame(input bit bp, input int eol_r, input int eol_c, input int drop_r,
                             input int sof_r, input int sof_c, input int wr_r, input int wr_s,
                             input int wr_e, input int rst_r);
        int r = 0;
        int c = 0;
        bit u, l;
        bit mid_done = 0;
        forever begin
            if (r == rst_r && c == 0) begin
                do_reset();
                return;
            end
            if (r == wr_r && c == 0) begin
                cfg_row_start = 3'(wr_s); cfg_row_end = 3'(wr_e); cfg_wr = 1'b1;
            end
            u = (r == 0 && c == 0) || (!mid_done && r == sof_r && c == sof_c);
            l = (c == W - 1 && r != drop_r) || (r == eol_r && c == eol_c);
            send(u, l, bp);
            if (u && !(r == 0 && c == 0)) begin
                mid_done = 1; r = 0; c = 1;
            end else if (l) begin
                if (r == H - 1) break;
                r++; c = 0;
            end else if (c == W - 1) begin
                break;
            end else begin
                c++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_en = 1'b1; cfg_wr = 1'b0; cfg_row_start = '0; cfg_row_end = '0;
        sif.s_tvalid = 1'b0; sif.s_tready = 1'b1; sif.s_tuser = 1'b0; sif.s_tlast = 1'b0;
        pend = '{default: 0};
        model_reset();
        clear_cnts();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        idle(1);

        // Nominal frame, window rows 2..3
        cfg_write(2, 3);
        clear_cnts();
        run_frame(0, -1, -1, -1, -1, -1, -1, 0, 0, -1);
        idle(2);
        check_eq("t1_pv_beats", pv_cnt, 16);
        check_eq("t1_roi_sof", sof_cnt, 1);
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_frame_cnt", 32'(frame_cnt), 1);

        // Backpressure
        clear_cnts();
        run_frame(1, -1, -1, -1, -1, -1, -1, 0, 0, -1);
        idle(2);
        check_eq("t2_pv_beats", pv_cnt, 16);
        check_eq("t2_done", done_cnt, 1);
        check_eq("t2_frame_cnt", 32'(frame_cnt), 2);

        // Early EOL at row 1 col 4
        clear_cnts();
        run_frame(0, 1, 4, -1, -1, -1, -1, 0, 0, -1);
        idle(2);
        check_eq("t3_early", early_cnt, 1);
        check_eq("t3_done", done_cnt, 1);
        check_eq("t3_pv_beats", pv_cnt, 16);

        // Late EOL: row 2 has no tlast
        clear_cnts();
        run_frame(0, -1, -1, 2, -1, -1, -1, 0, 0, -1);
        idle(1);
        check_eq("t4_late", late_cnt, 1);
        check_eq("t4_done", done_cnt, 0);
        check_eq("t4_busy", 32'(busy), 0);
        check_eq("t4_pv_beats", pv_cnt, 8);
        clear_cnts();
        for (int i = 0; i < 10; i++) send(0, (i == 7), 0);
        idle(2);
        check_eq("t4_dropped_pv", pv_cnt, 0);
        check_eq("t4_cnt_hold", 32'(frame_cnt), 3);

        // Mid-frame SOF at row 3 col 2; shadow rewritten to 0..1 at row 1
        clear_cnts();
        run_frame(0, -1, -1, -1, 3, 2, 1, 0, 1, -1);
        idle(2);
        check_eq("t5_mid", mid_cnt, 1);
        check_eq("t5_done", done_cnt, 1);
        check_eq("t5_early", early_cnt, 0);

        // Config timing: start=4 written at row 1 applies to the next frame
        clear_cnts();
        run_frame(0, -1, -1, -1, -1, -1, 1, 4, 5, -1);
        idle(2);
        check_eq("t6_old_win_pv", pv_cnt, 16);
        clear_cnts();
        run_frame(1, -1, -1, -1, -1, -1, -1, 0, 0, -1);
        idle(2);
        check_eq("t6_new_win_pv", pv_cnt, 16);
        check_eq("t6_new_win_sof", sof_cnt, 1);
        check_eq("t6_frame_cnt", 32'(frame_cnt), 6);

        // Reset at row 3, then non-SOF beats must be dropped
        run_frame(0, -1, -1, -1, -1, -1, -1, 0, 0, 3);
        clear_cnts();
        for (int i = 0; i < 9; i++) send(0, (i == 7), 0);
        idle(2);
        check_eq("t6_post_rst_pv", pv_cnt, 0);
        check_eq("t6_post_rst_busy", 32'(busy), 0);

        // cfg_en low: SOF beats are not accepted
        cfg_en = 1'b0;
        clear_cnts();
        for (int i = 0; i < 3; i++) send(1, 0, 0);
        idle(2);
        check_eq("t7_en_off_pv", pv_cnt, 0);
        check_eq("t7_en_off_busy", 32'(busy), 0);
        cfg_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
